// File: rtl/led_display_arbiter.sv
// led_display_arbiter: round-robin arbiter sharing the 8-bit LED output between pattern sources
//
// Each granted source has its pattern latched and shown for HOLD_TICKS prescaled
// ticks. The grant is then released through a one-cycle DONE state, and priority
// rotates to the source after the winner.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   req        level request per source; hold until done/aborted
//   pattern_in pattern of source i at [8*i+7:8*i]
//   grant      one-hot registered grant, all-zero when idle
//   led_out    registered display value
//   busy       high while a pattern is shown
//   done       one-cycle pulse at release
//   aborted    one-cycle pulse with done when release was early
//
// Optional feature: define LED_ARB_PREEMPT_EN to give req[0] absolute priority.
// Source 0 then wins arbitration unconditionally and preempts any other source
// that is being shown.
module led_display_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [23:0] TICK_DIV     = 24'd10_000_000,
  parameter logic [7:0]  HOLD_TICKS   = 8'd4,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] pattern_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           led_out,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, rr_n, win_q, win_n, win;
  logic [23:0] prescaler, pre_n;
  logic [7:0] tick_cnt, tick_n, led_n, pat;
  logic [NUM_REQ-1:0] grant_n, rot;
  logic busy_n, done_n, abort_n, preempt, tick;
  // Requests rotated so bit 0 is rr_ptr. The downward scan keeps the lowest set bit,
  // which is the first requester at or after rr_ptr.
  always_comb begin
    rot = NUM_REQ'({req, req} >> rr_ptr);
    win = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) win = IW'((int'(rr_ptr) + k) % NUM_REQ);
`ifdef LED_ARB_PREEMPT_EN
    if (req[0]) win = '0;
    preempt = req[0] && !grant[0];
`else
    preempt = 1'b0;
`endif
    pat = 8'(pattern_in >> {win, 3'b000});
  end
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    win_n   = win_q;
    pre_n   = prescaler;
    tick_n  = tick_cnt;
    grant_n = grant;
    led_n   = led_out;
    busy_n  = busy;
    done_n  = 1'b0;
    abort_n = 1'b0;
    tick    = prescaler == TICK_DIV - 24'd1;
    case (state)
      IDLE: if (|req) begin
        state_n = SHOW;
        win_n   = win;
        grant_n = NUM_REQ'(1) << win;
        led_n   = pat;
        pre_n   = '0;
        tick_n  = '0;
        busy_n  = 1'b1;
      end
      SHOW: begin
        pre_n  = tick ? 24'd0 : prescaler + 24'd1;
        tick_n = tick ? tick_cnt + 8'd1 : tick_cnt;
        // The winner's request is checked through grant, which is one-hot on the winner.
        // A dropped request takes precedence over a coincident final tick.
        abort_n = !(|(req & grant)) || preempt;
        if (abort_n || (tick && tick_cnt == HOLD_TICKS - 8'd1)) begin
          state_n = DONE;
          done_n  = 1'b1;
          grant_n = '0;
          led_n   = IDLE_PATTERN;
          busy_n  = 1'b0;
          pre_n   = '0;
          tick_n  = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        rr_n    = IW'((int'(win_q) + 1) % NUM_REQ);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_q     <= '0;
      prescaler <= '0;
      tick_cnt  <= '0;
      grant     <= '0;
      led_out   <= IDLE_PATTERN;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      win_q     <= win_n;
      prescaler <= pre_n;
      tick_cnt  <= tick_n;
      grant     <= grant_n;
      led_out   <= led_n;
      busy      <= busy_n;
      done      <= done_n;
      aborted   <= abort_n;
    end
  end
endmodule
